// File: rtl/clk_freq_meter.sv
//-----------------------------------------------------------------------------
// clk_freq_meter
//
// Purpose:
//   Measures the frequency of an asynchronous clock (meas_clk) by counting its
//   rising edges over a fixed gate window of the reference clock (clk). It
//   reports the count and flags it as too slow, too fast or stuck, so that
//   bring-up software can confirm that clock generation is working.
//
//   A free-running binary counter in the meas_clk domain is Gray-coded,
//   carried into the clk domain through a 2-flop synchroniser and converted
//   back to binary ("snap"). The count for one window is the difference
//   between two snaps. Back-to-back windows share their boundary snap, so no
//   edge is lost between windows.
//
// Optional feature (macro CLK_FREQ_METER_HIST_EN):
//   Adds min_count / max_count, the extremes of all reported counts since
//   reset, and a hist_clr input that restores min_count to all-ones and
//   max_count to 0. If hist_clr and a report fall in the same cycle,
//   hist_clr wins.
//
// Ports:
//   clk          in   reference clock; every output is in this domain
//   rst_n        in   asynchronous active-low reset (deassertion is
//                     synchronised separately into each clock domain)
//   meas_clk     in   clock under measurement, asynchronous to clk
//   enable       in   level; while high, windows run back-to-back
//   count        out  meas_clk rising edges in the last completed window
//   count_valid  out  one-cycle pulse when count updates
//   too_slow     out  last count < EXP_MIN
//   too_fast     out  last count > EXP_MAX
//   stuck        out  last count == 0
//   state_dbg    out  current FSM state (IDLE=0, ARM=1, GATE=2, REPORT=3)
//   hist_clr     in   (CLK_FREQ_METER_HIST_EN only) clear min/max history
//   min_count    out  (CLK_FREQ_METER_HIST_EN only) smallest count seen
//   max_count    out  (CLK_FREQ_METER_HIST_EN only) largest count seen
//
// Interface semantics: enable is a plain level with no handshake. count_valid
// is a single-cycle strobe with no back-pressure; count and flags are stable
// from that strobe until the next one.
//
// The product f_meas * window must stay below 2^CNT_W; counter wrap inside a
// window is not detected.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module clk_freq_meter #(
  parameter int GATE_CYCLES = 50000,
  parameter int CNT_W       = 20,
  parameter int EXP_MIN     = 11000,
  parameter int EXP_MAX     = 11120
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             meas_clk,
  input  logic             enable,
`ifdef CLK_FREQ_METER_HIST_EN
  input  logic             hist_clr,
  output logic [CNT_W-1:0] min_count,
  output logic [CNT_W-1:0] max_count,
`endif
  output logic [CNT_W-1:0] count,
  output logic             count_valid,
  output logic             too_slow,
  output logic             too_fast,
  output logic             stuck,
  output logic [1:0]       state_dbg
);

  localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] EXP_MIN_C = CNT_W'(EXP_MIN);
  localparam logic [CNT_W-1:0] EXP_MAX_C = CNT_W'(EXP_MAX);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    GATE   = 2'd2,
    REPORT = 2'd3
  } state_t;

  //---------------------------------------------------------------------------
  // Reset synchronisers: assert asynchronously, release after two edges of
  // the local clock.
  //---------------------------------------------------------------------------
  logic [1:0] rst_c_q, rst_c_d;
  logic [1:0] rst_m_q, rst_m_d;
  logic       rst_c_n;
  logic       rst_m_n;

  always_comb begin
    rst_c_d = {rst_c_q[0], 1'b1};
    rst_m_d = {rst_m_q[0], 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_c_q <= 2'b00;
    else        rst_c_q <= rst_c_d;
  end

  always_ff @(posedge meas_clk or negedge rst_n) begin
    if (!rst_n) rst_m_q <= 2'b00;
    else        rst_m_q <= rst_m_d;
  end

  assign rst_c_n = rst_c_q[1];
  assign rst_m_n = rst_m_q[1];

  //---------------------------------------------------------------------------
  // meas_clk domain: free-running edge counter and its registered Gray copy.
  // Only one bit of the Gray value changes per edge, so the clk-domain
  // sampler sees either the old or the new value, never a mix.
  //---------------------------------------------------------------------------
  logic [CNT_W-1:0] meas_bin_q,  meas_bin_d;
  logic [CNT_W-1:0] meas_gray_q, meas_gray_d;

  always_comb begin
    meas_bin_d  = meas_bin_q + 1'b1;
    meas_gray_d = meas_bin_q ^ (meas_bin_q >> 1);
  end

  always_ff @(posedge meas_clk or negedge rst_m_n) begin
    if (!rst_m_n) begin
      meas_bin_q  <= '0;
      meas_gray_q <= '0;
    end else begin
      meas_bin_q  <= meas_bin_d;
      meas_gray_q <= meas_gray_d;
    end
  end

  //---------------------------------------------------------------------------
  // clk domain: 2-flop Gray synchroniser and Gray-to-binary conversion.
  //---------------------------------------------------------------------------
  logic [CNT_W-1:0] gray_s1_q, gray_s1_d;
  logic [CNT_W-1:0] gray_s2_q, gray_s2_d;
  logic [CNT_W-1:0] snap;

  function automatic logic [CNT_W-1:0] gray2bin(input logic [CNT_W-1:0] g);
    logic [CNT_W-1:0] b;
    b[CNT_W-1] = g[CNT_W-1];
    for (int i = CNT_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  always_comb begin
    gray_s1_d = meas_gray_q;
    gray_s2_d = gray_s1_q;
    snap      = gray2bin(gray_s2_q);
  end

  //---------------------------------------------------------------------------
  // Measurement FSM and registered outputs.
  //---------------------------------------------------------------------------
  state_t           state_q,       state_d;
  logic [1:0]       arm_cnt_q,     arm_cnt_d;
  logic [GW-1:0]    gate_cnt_q,    gate_cnt_d;
  logic [CNT_W-1:0] start_q,       start_d;
  logic [CNT_W-1:0] count_q,       count_d;
  logic             count_valid_q, count_valid_d;
  logic             too_slow_q,    too_slow_d;
  logic             too_fast_q,    too_fast_d;
  logic             stuck_q,       stuck_d;
  logic [CNT_W-1:0] diff;
`ifdef CLK_FREQ_METER_HIST_EN
  logic [CNT_W-1:0] min_q, min_d;
  logic [CNT_W-1:0] max_q, max_d;
`endif

  // Modular subtraction gives the right answer across counter wrap.
  assign diff = snap - start_q;

  always_comb begin
    state_d       = state_q;
    arm_cnt_d     = arm_cnt_q;
    gate_cnt_d    = gate_cnt_q;
    start_d       = start_q;
    count_d       = count_q;
    count_valid_d = 1'b0;
    too_slow_d    = too_slow_q;
    too_fast_d    = too_fast_q;
    stuck_d       = stuck_q;

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d   = ARM;
          arm_cnt_d = 2'd0;
        end
      end
      ARM: begin
        // Three cycles let a fresh Gray value reach snap before the first
        // window boundary is latched.
        if (arm_cnt_q == 2'd2) begin
          start_d    = snap;
          gate_cnt_d = '0;
          state_d    = GATE;
        end else begin
          arm_cnt_d = arm_cnt_q + 2'd1;
        end
      end
      GATE: begin
        if (gate_cnt_q == GATE_LAST) begin
          state_d = REPORT;
        end else begin
          gate_cnt_d = gate_cnt_q + 1'b1;
        end
      end
      REPORT: begin
        count_d       = diff;
        count_valid_d = 1'b1;
        too_slow_d    = (diff < EXP_MIN_C);
        too_fast_d    = (diff > EXP_MAX_C);
        stuck_d       = (diff == '0);
        // The closing snap of this window opens the next one.
        start_d       = snap;
        gate_cnt_d    = '0;
        state_d       = enable ? GATE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef CLK_FREQ_METER_HIST_EN
  always_comb begin
    min_d = min_q;
    max_d = max_q;
    if (hist_clr) begin
      min_d = '1;
      max_d = '0;
    end else if (state_q == REPORT) begin
      if (diff < min_q) min_d = diff;
      if (diff > max_q) max_d = diff;
    end
  end

  always_ff @(posedge clk or negedge rst_c_n) begin
    if (!rst_c_n) begin
      min_q <= '1;
      max_q <= '0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
    end
  end

  assign min_count = min_q;
  assign max_count = max_q;
`endif

  always_ff @(posedge clk or negedge rst_c_n) begin
    if (!rst_c_n) begin
      gray_s1_q     <= '0;
      gray_s2_q     <= '0;
      state_q       <= IDLE;
      arm_cnt_q     <= 2'd0;
      gate_cnt_q    <= '0;
      start_q       <= '0;
      count_q       <= '0;
      count_valid_q <= 1'b0;
      too_slow_q    <= 1'b0;
      too_fast_q    <= 1'b0;
      stuck_q       <= 1'b0;
    end else begin
      gray_s1_q     <= gray_s1_d;
      gray_s2_q     <= gray_s2_d;
      state_q       <= state_d;
      arm_cnt_q     <= arm_cnt_d;
      gate_cnt_q    <= gate_cnt_d;
      start_q       <= start_d;
      count_q       <= count_d;
      count_valid_q <= count_valid_d;
      too_slow_q    <= too_slow_d;
      too_fast_q    <= too_fast_d;
      stuck_q       <= stuck_d;
    end
  end

  assign count       = count_q;
  assign count_valid = count_valid_q;
  assign too_slow    = too_slow_q;
  assign too_fast    = too_fast_q;
  assign stuck       = stuck_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_clk_freq_meter.sv
//-----------------------------------------------------------------------------
// tb_clk_freq_meter
//
// Bench for clk_freq_meter with a 1000-cycle gate (clk = 50 MHz). The model
// predicts, from the measured-clock period, the range a window count may take
// (window = GATE+1 reference cycles, +/-1 sampling), the flags that range
// implies, and the cycle of every count_valid pulse (first pulse GATE+4
// cycles after enable is sampled, then every GATE+1 cycles while enable is
// held). Expected pulse cycles live in exp_q.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_clk_freq_meter;

  localparam int G       = 1000;
  localparam int CW      = 20;
  localparam int EXP_MIN = 219;
  localparam int EXP_MAX = 224;

  logic          clk;
  logic          rst_n;
  logic          meas_clk;
  logic          enable;
  logic [CW-1:0] count;
  logic          count_valid;
  logic          too_slow;
  logic          too_fast;
  logic          stuck;
  logic [1:0]    state_dbg;
`ifdef CLK_FREQ_METER_HIST_EN
  logic          hist_clr;
  logic [CW-1:0] min_count;
  logic [CW-1:0] max_count;
`endif

  clk_freq_meter #(
    .GATE_CYCLES(G),
    .CNT_W      (CW),
    .EXP_MIN    (EXP_MIN),
    .EXP_MAX    (EXP_MAX)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .meas_clk   (meas_clk),
    .enable     (enable),
`ifdef CLK_FREQ_METER_HIST_EN
    .hist_clr   (hist_clr),
    .min_count  (min_count),
    .max_count  (max_count),
`endif
    .count      (count),
    .count_valid(count_valid),
    .too_slow   (too_slow),
    .too_fast   (too_fast),
    .stuck      (stuck),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock / reset block ----------------
  int  cyc = 0;
  real meas_half = 45.211;
  bit  meas_run  = 1'b1;

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Measured clock: held low while meas_run is 0; restarts with a small
  // phase offset so its edges stay clear of clk edges.
  initial begin
    meas_clk = 1'b0;
    #3;
    forever begin
      if (!meas_run) begin
        meas_clk = 1'b0;
        wait (meas_run);
        #3;
      end else begin
        #(meas_half);
        meas_clk = ~meas_clk;
      end
    end
  end

  // ---------------- scoreboard / model ----------------
  int          n_checks  = 0;
  int          n_err     = 0;
  int          n_reports = 0;
  logic [31:0] exp_q[$];
  int          exp_lo, exp_hi;
  logic        exp_slow, exp_fast, exp_stuck;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d..%0d (t=%0t)", name, act, lo, hi, $time);
    end
  endtask

  // Model of one window at a given measured-clock period.
  task automatic set_freq(input real period_ns);
    real x;
    meas_half = period_ns / 2.0;
    x         = real'(G + 1) * 20.0 / period_ns;
    exp_lo    = $rtoi($floor(x)) - 1;
    exp_hi    = $rtoi($ceil(x));
    exp_slow  = (exp_hi < EXP_MIN);
    exp_fast  = (exp_lo > EXP_MAX);
    exp_stuck = 1'b0;
  endtask

  task automatic set_stopped();
    exp_lo    = 0;
    exp_hi    = 0;
    exp_slow  = (EXP_MIN > 0);
    exp_fast  = 1'b0;
    exp_stuck = 1'b1;
  endtask

  // Compare process: every cycle, a pulse must occur exactly where the model
  // expects one and nowhere else; each pulse is checked against the model.
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (exp_q.size() > 0 && cyc == int'(exp_q[0])) begin
        void'(exp_q.pop_front());
        chk("count_valid_on_time", {31'd0, count_valid}, 32'd1);
        if (count_valid) begin
          n_reports++;
          chk_range("count", int'(count), exp_lo, exp_hi);
          chk("too_slow", {31'd0, too_slow}, {31'd0, exp_slow});
          chk("too_fast", {31'd0, too_fast}, {31'd0, exp_fast});
          chk("stuck",    {31'd0, stuck},    {31'd0, exp_stuck});
          if (enable) exp_q.push_back(32'(cyc + G + 1));
          else        chk("idle_after_last_report", {30'd0, state_dbg}, 32'd0);
        end
      end else if (count_valid) begin
        chk("count_valid_unexpected", {31'd0, count_valid}, 32'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_enable();
    @(negedge clk);
    enable = 1'b1;
    exp_q.push_back(32'(cyc + 1 + G + 4));
  endtask

  task automatic stop_enable();
    @(negedge clk);
    enable = 1'b0;
  endtask

  task automatic wait_reports(input int n);
    int target = n_reports + n;
    int budget = n * (G + 1) + G + 50;
    while (n_reports < target && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (n_reports < target) chk("wait_reports_timeout", 32'(n_reports), 32'(target));
  endtask

  task automatic wait_idle();
    int budget = 2 * G + 50;
    while ((exp_q.size() != 0 || state_dbg != 2'd0) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) chk("wait_idle_timeout", {30'd0, state_dbg}, 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_count"},       32'(count),              32'd0);
    chk({tag, "_count_valid"}, {31'd0, count_valid},    32'd0);
    chk({tag, "_too_slow"},    {31'd0, too_slow},       32'd0);
    chk({tag, "_too_fast"},    {31'd0, too_fast},       32'd0);
    chk({tag, "_stuck"},       {31'd0, stuck},          32'd0);
    chk({tag, "_state"},       {30'd0, state_dbg},      32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k;
    rst_n  = 1'b0;
    enable = 1'b0;
`ifdef CLK_FREQ_METER_HIST_EN
    hist_clr = 1'b0;
`endif
    set_freq(90.422);
    #1;
    chk_all_zero("reset_async");
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk_all_zero("after_reset");

    // 11.0592 MHz: in range, no flags.
    set_freq(90.422);
    chk("model_lo_11m", 32'(exp_lo), 32'd220);
    chk("model_hi_11m", 32'(exp_hi), 32'd222);
    start_enable();
    wait_reports(3);
    stop_enable();
    wait_idle();

    // 10 MHz: too slow.
    set_freq(100.0);
    chk("model_lo_10m", 32'(exp_lo), 32'd199);
    chk("model_hi_10m", 32'(exp_hi), 32'd201);
    chk("model_slow_10m", {31'd0, exp_slow}, 32'd1);
    start_enable();
    wait_reports(2);
    stop_enable();
    wait_idle();

    // 40 MHz: too fast, then a short asynchronous reset mid-window.
    set_freq(25.0);
    chk("model_lo_40m", 32'(exp_lo), 32'd799);
    chk("model_hi_40m", 32'(exp_hi), 32'd801);
    chk("model_fast_40m", {31'd0, exp_fast}, 32'd1);
    start_enable();
    wait_reports(2);
    chk("pre_reset_too_fast", {31'd0, too_fast}, 32'd1);
    repeat (500) @(negedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk_all_zero("midgate_reset");
    #2;
    rst_n = 1'b1;
    k = cyc;
    // Two clk edges to release the synchronised reset, one more to see enable.
    exp_q.push_back(32'(k + 3 + G + 4));
    wait_reports(1);
    stop_enable();
    wait_idle();

    // Stopped measured clock, single-cycle enable pulse.
    meas_run = 1'b0;
    set_stopped();
    repeat (10) @(negedge clk);
    @(negedge clk);
    enable = 1'b1;
    exp_q.push_back(32'(cyc + 1 + G + 4));
    @(negedge clk);
    enable = 1'b0;
    wait_idle();
    chk("stuck_count",    32'(count),           32'd0);
    chk("stuck_flag",     {31'd0, stuck},       32'd1);
    chk("stuck_too_slow", {31'd0, too_slow},    32'd1);
    chk("stuck_too_fast", {31'd0, too_fast},    32'd0);
    chk("stuck_idle",     {30'd0, state_dbg},   32'd0);

`ifdef CLK_FREQ_METER_HIST_EN
    // History: clear, then alternate 10 MHz and 11.0592 MHz windows.
    meas_run = 1'b1;
    @(negedge clk);
    hist_clr = 1'b1;
    @(negedge clk);
    hist_clr = 1'b0;
    chk("hist_clr_min", 32'(min_count), 32'((1 << CW) - 1));
    chk("hist_clr_max", 32'(max_count), 32'd0);
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) set_freq(100.0);
      else            set_freq(90.422);
      repeat (5) @(negedge clk);
      @(negedge clk);
      enable = 1'b1;
      exp_q.push_back(32'(cyc + 1 + G + 4));
      @(negedge clk);
      enable = 1'b0;
      wait_idle();
    end
    chk_range("hist_min", int'(min_count), 199, 201);
    chk_range("hist_max", int'(max_count), 220, 222);
    @(negedge clk);
    hist_clr = 1'b1;
    @(negedge clk);
    hist_clr = 1'b0;
    chk("hist_clr2_min", 32'(min_count), 32'((1 << CW) - 1));
    chk("hist_clr2_max", 32'(max_count), 32'd0);
`endif

    repeat (20) @(negedge clk);
    chk("no_pending_reports", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/clk_freq_meter.md
Name: clk_freq_meter

Overview:
- Synthesizable clock checker; the consuming end of the board/testbench clock set.
- Counts edges of one measured clock (e.g. 11.0592 MHz UART clock, 10 MHz, base) over a fixed gate window of the reference clock.
- Reports the count and flags it as too slow, too fast or stuck.
- Used in bring-up and self-test so software can verify clock generation.

Parameters:
- GATE_CYCLES, 50000: gate window length in clk cycles (1 ms at 50 MHz).
- CNT_W, 20: width of the edge counter and of the result.
- EXP_MIN, 11000: lowest acceptable count per window.
- EXP_MAX, 11120: highest acceptable count per window.

Ports:
- clk  in  1  reference clock (50 MHz domain); all outputs are in this domain.
- rst_n  in  1  asynchronous active-low reset.
- meas_clk  in  1  clock under measurement, asynchronous to clk.
- enable  in  1  level; while high, windows run back-to-back.
- count  out  CNT_W  meas_clk rising edges counted in the last completed window.
- count_valid  out  1  one-cycle pulse when count updates.
- too_slow  out  1  last count < EXP_MIN.
- too_fast  out  1  last count > EXP_MAX.
- stuck  out  1  last count == 0.

Behaviour:
- Reset:
  - rst_n low asserts reset asynchronously in both domains.
  - Deassertion is synchronised separately into each domain (2-flop).
  - All outputs reset to 0. State resets to IDLE.
- meas_clk domain:
  - Free-running CNT_W-bit binary counter, +1 per meas_clk rising edge, wraps modulo 2^CNT_W.
  - Its Gray-coded copy is registered on meas_clk.
- clk domain:
  - Gray value passes through a 2-flop synchroniser, then is converted to binary (snap).
- FSM (clk domain):
  - IDLE: wait for enable=1, then go to ARM.
  - ARM: 3 cycles to flush the synchroniser. Latch start=snap, then go to GATE with the gate counter at 0.
  - GATE: gate counter increments each cycle. On reaching GATE_CYCLES-1, go to REPORT.
  - REPORT (1 cycle):
    - count = (snap - start) mod 2^CNT_W.
    - Update flags, pulse count_valid.
    - Set start=snap.
    - If enable=1, go to GATE (no re-arm gap, no lost edges). Otherwise go to IDLE.
- enable deasserted mid-GATE: the window finishes and reports, then the FSM goes to IDLE. No window is aborted.
- Flags and count hold their values between reports.
- Accuracy: ±1 count (synchroniser sampling).
- Integration requirement: f_meas × window < 2^CNT_W. Wrap is not detected.
- meas_clk stopped: snap is frozen, count = 0, stuck=1, too_slow=1 (when EXP_MIN > 0).
- Latency: count_valid occurs GATE_CYCLES+4 clk cycles after enable rises for the first window, then every GATE_CYCLES+1 cycles.

Optional Feature:
- Macro: CLK_FREQ_METER_HIST_EN.
- When defined:
  - Adds outputs min_count and max_count (CNT_W each).
  - They update on each count_valid and track the extremes since reset.
  - Initial values after reset: min_count = all-ones, max_count = 0.
  - Adds input hist_clr (1 bit, clk domain), which restores those initial values.
  - If hist_clr and count_valid fall in the same cycle, hist_clr wins.
- When undefined: no such ports or registers exist.

Test Plan:
- GATE_CYCLES=1000, EXP_MIN=219, EXP_MAX=224, meas_clk 11.0592 MHz (period 90422 ps), enable held -> every count in 220..222; too_slow=too_fast=stuck=0; count_valid period 1001 cycles.
- Same, meas_clk 10 MHz -> count 199..201, too_slow=1, too_fast=0.
- Same, meas_clk 40 MHz (base) -> count 799..801, too_fast=1.
- meas_clk held low, enable pulsed 1 cycle -> exactly one count_valid after 1004 cycles; count=0, stuck=1, too_slow=1; FSM back in IDLE.
- rst_n low for 3 ns mid-GATE -> all outputs 0 immediately (asynchronous, without a clk edge); no count_valid until 1004 cycles after rst_n high with enable=1.
- CLK_FREQ_METER_HIST_EN, alternate 10 MHz / 11.0592 MHz windows -> min_count≈200, max_count≈221; hist_clr pulse -> min_count all-ones, max_count 0.
